mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory of the multicycle core between two requesters:
//  the core (fetch and load/store, driven by Controller AdrSrc/MemWrite timing) and the program loader.
//  Grants one access at a time, tracks fixed memory read latency, returns read data and a valid strobe.
//  Sits between the core memory interface and the memory macro.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  MEM_LAT  1   cycles from issue (m_en) to m_rdata valid; legal range 1..4
// PORTS
//  clk       in   1       clock, all logic on rising edge
//  reset     in   1       synchronous, active-high
//  c_req     in   1       core access request; held until c_gnt
//  c_we      in   1       core write (1) / read (0)
//  c_addr    in   ADDR_W  core address
//  c_wdata   in   DATA_W  core write data
//  c_gnt     out  1       core request accepted and issued this cycle
//  c_rvalid  out  1       core read data valid this cycle
//  l_req/l_we/l_addr/l_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as core
//  l_gnt     out  1       loader request accepted and issued this cycle
//  l_rvalid  out  1       loader read data valid this cycle
//  rdata     out  DATA_W  read data, = m_rdata; qualified only by c_rvalid/l_rvalid
//  m_en      out  1       memory access strobe
//  m_we      out  1       memory write enable
//  m_addr    out  ADDR_W  memory address
//  m_wdata   out  DATA_W  memory write data
//  m_rdata   in   DATA_W  memory read data
// BEHAVIOUR
//  - Clock clk; reset synchronous, active-high; all regs update only on rising clk.
//  - Reset: state=IDLE, cnt=0, last_owner=LOADER (core wins first tie); all outputs 0 except rdata=m_rdata.
//  - States: IDLE, RD_WAIT.
//  - IDLE, no req: m_en=0, gnt=0.
//  - IDLE, any req: pick winner; same cycle (combinational) m_en=1, m_we/m_addr/m_wdata from winner,
//    winner gnt=1 (loser gnt=0), last_owner<=winner. Write: stay IDLE (one write per cycle max).
//    Read: ->RD_WAIT, cnt<=MEM_LAT-1, owner<=winner.
//  - RD_WAIT: m_en=0, all gnt=0; cnt decrements each cycle; when cnt==0 assert owner rvalid for
//    exactly 1 cycle, ->IDLE. Read issued at T gives rvalid at T+MEM_LAT; next issue earliest T+MEM_LAT+1.
//  - Pick: only one req -> it wins; both -> the one not equal to last_owner (2-way round-robin).
//  - Requester rule: req/we/addr/wdata stable while req=1 and gnt=0; after gnt, req may stay high for a new access.
//  - Requests arriving during RD_WAIT wait; no queueing beyond the held req.
//  - Reset in RD_WAIT: access aborted, no rvalid, state IDLE next cycle.
//  - cnt width $clog2(MEM_LAT+1); MEM_LAT=1 means single RD_WAIT cycle with cnt==0.
//  - c_rvalid and l_rvalid never both 1; c_gnt and l_gnt never both 1.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: on tie core always wins; last_owner still updated but ignored.
//  Undefined (default): round-robin as above; loader cannot be starved by continuous core reqs.
// STRUCTURE
//  Package mem_arb_pkg: state enum {IDLE, RD_WAIT}, owner encoding {OWN_CORE, OWN_LOADER},
//  MEM_LAT_MAX=4 constant.
//  Sub-module arb_rr_pick: combinational 2-way picker (req[1:0], last_owner) -> grant one-hot; holds the
//  ARB_FIXED_PRIO_EN ifdef. FSM, counter, mux stay in top.
// TESTING
//  1. Reset, core read addr 0x10, MEM_LAT=1 -> c_gnt at T, m_en/m_addr=0x10 at T, c_rvalid at T+1, rdata=m_rdata.
//  2. Both req reads same cycle after reset -> core granted first, loader granted at T+MEM_LAT+1;
//     repeat continuously -> grants alternate C,L,C,L.
//  3. Core write 0xDEADBEEF@0x20 then read 0x20 (held req) -> write issued T, read issued T+1, rvalid T+1+MEM_LAT, data 0xDEADBEEF.
//  4. MEM_LAT=3, loader read -> no gnt to core during 3 wait cycles, l_rvalid only at T+3.
//  5. Assert reset in 1st RD_WAIT cycle -> no rvalid ever for that read, IDLE after reset, core wins next tie.
//  6. Build with ARB_FIXED_PRIO_EN, both reqs held for 6 accesses -> core granted every time, l_gnt=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   state_t : arbiter FSM states (IDLE, RD_WAIT)
//   owner_t : requester encoding (OWN_CORE, OWN_LOADER)
//   MEM_LAT_MAX : largest supported memory read latency
package mem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_CORE   = 1'b0,
        OWN_LOADER = 1'b1
    } owner_t;

    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way picker for the memory port arbiter.
// Configuration macro: ARB_FIXED_PRIO_EN
//   undefined : on a tie the requester that did not win last time is picked
//   defined   : on a tie the core always wins; i_last_owner is ignored
// Ports:
//   i_req        [1:0] request vector, bit 0 = core, bit 1 = loader
//   i_last_owner       winner of the previous access
//   o_gnt        [1:0] one-hot pick (all zero when no request)
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last_owner,
    output logic [1:0] o_gnt
);

`ifdef ARB_FIXED_PRIO_EN
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;

    always_comb begin
        o_gnt    = 2'b00;
        o_gnt[0] = i_req[0];
        o_gnt[1] = i_req[1] & ~i_req[0];
    end
`else
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_last_owner == OWN_CORE) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the core and the program
// loader. One access is issued per grant; reads are tracked for a fixed memory
// latency and the owner's rvalid is strobed when m_rdata is valid.
// Optional tie-break mode selected by macro ARB_FIXED_PRIO_EN (see arb_rr_pick).
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata       core request, held until c_gnt
//   c_gnt, c_rvalid                 core issue strobe, core read data valid
//   l_req/l_we/l_addr/l_wdata       loader request, held until l_gnt
//   l_gnt, l_rvalid                 loader issue strobe, loader read data valid
//   rdata                           read data (straight from m_rdata)
//   m_en/m_we/m_addr/m_wdata        memory access strobe and command
//   m_rdata                         memory read data
// MEM_LAT legal range is 1..MEM_LAT_MAX.
//
// state   | meaning
// IDLE    | free; a request present this cycle is issued combinationally
// RD_WAIT | read outstanding; r_cnt counts down, rvalid when it reaches 0
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_t           r_state;
    owner_t           r_owner;
    owner_t           r_last_owner;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0] w_pick;
    owner_t     w_winner;
    logic       w_issue;
    logic       w_done;

    arb_rr_pick u_pick (
        .i_req        ({l_req, c_req}),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_pick)
    );

    assign w_winner = w_pick[1] ? OWN_LOADER : OWN_CORE;
    // Outputs are forced low during reset, including an rvalid that would
    // otherwise be decoded from a read being aborted.
    assign w_issue  = !reset && (r_state == IDLE) && (c_req || l_req);
    assign w_done   = !reset && (r_state == RD_WAIT) && (r_cnt == '0);

    assign c_gnt    = w_issue && !w_pick[1];
    assign l_gnt    = w_issue &&  w_pick[1];
    assign m_en     = w_issue;
    assign m_we     = w_issue && ((w_winner == OWN_LOADER) ? l_we : c_we);
    assign m_addr   = !w_issue ? '0 : (w_winner == OWN_LOADER) ? l_addr  : c_addr;
    assign m_wdata  = !w_issue ? '0 : (w_winner == OWN_LOADER) ? l_wdata : c_wdata;

    assign c_rvalid = w_done && (r_owner == OWN_CORE);
    assign l_rvalid = w_done && (r_owner == OWN_LOADER);
    assign rdata    = m_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_owner      <= OWN_CORE;
            r_last_owner <= OWN_LOADER;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_last_owner <= w_winner;
                        // Writes complete in the issue cycle; only reads wait.
                        if (!m_we) begin
                            r_state <= RD_WAIT;
                            r_owner <= w_winner;
                            r_cnt   <= CNT_W'(MEM_LAT - 1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    typedef struct {
        logic        rst;
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        l_req;
        logic        l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        e_cg;
        logic        e_lg;
        logic        e_men;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_cv;
        logic        e_lv;
        logic [31:0] e_rdata;
    } vec_t;

    logic clk;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Instance with MEM_LAT = 1
    logic        rst1, c_req1, c_we1, l_req1, l_we1;
    logic [31:0] c_addr1, c_wdata1, l_addr1, l_wdata1;
    logic        c_gnt1, c_rvalid1, l_gnt1, l_rvalid1, m_en1, m_we1;
    logic [31:0] rdata1, m_addr1, m_wdata1, m_rdata1;

    // Instance with MEM_LAT = 3
    logic        rst3, c_req3, c_we3, l_req3, l_we3;
    logic [31:0] c_addr3, c_wdata3, l_addr3, l_wdata3;
    logic        c_gnt3, c_rvalid3, l_gnt3, l_rvalid3, m_en3, m_we3;
    logic [31:0] rdata3, m_addr3, m_wdata3, m_rdata3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(rst1),
        .c_req(c_req1), .c_we(c_we1), .c_addr(c_addr1), .c_wdata(c_wdata1),
        .c_gnt(c_gnt1), .c_rvalid(c_rvalid1),
        .l_req(l_req1), .l_we(l_we1), .l_addr(l_addr1), .l_wdata(l_wdata1),
        .l_gnt(l_gnt1), .l_rvalid(l_rvalid1),
        .rdata(rdata1), .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1),
        .m_wdata(m_wdata1), .m_rdata(m_rdata1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(rst3),
        .c_req(c_req3), .c_we(c_we3), .c_addr(c_addr3), .c_wdata(c_wdata3),
        .c_gnt(c_gnt3), .c_rvalid(c_rvalid3),
        .l_req(l_req3), .l_we(l_we3), .l_addr(l_addr3), .l_wdata(l_wdata3),
        .l_gnt(l_gnt3), .l_rvalid(l_rvalid3),
        .rdata(rdata3), .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3),
        .m_wdata(m_wdata3), .m_rdata(m_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: word array, initial word i = A5000000 | i.
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] pipe3 [3];

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = init_word(i);
            mem3[i] = init_word(i);
        end
        m_rdata1 = 32'h0;
        for (int i = 0; i < 3; i++) pipe3[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (m_en1 && m_we1)  mem1[m_addr1[9:2]] <= m_wdata1;
        if (m_en1 && !m_we1) m_rdata1 <= mem1[m_addr1[9:2]];
    end

    always @(posedge clk) begin
        if (m_en3 && m_we3) mem3[m_addr3[9:2]] <= m_wdata3;
        pipe3[0] <= (m_en3 && !m_we3) ? mem3[m_addr3[9:2]] : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign m_rdata3 = pipe3[2];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwdata,
        input logic lreq, input logic lwe, input logic [31:0] laddr, input logic [31:0] lwdata,
        input logic cg, input logic lg, input logic men, input logic mwe,
        input logic [31:0] maddr, input logic [31:0] mwdata,
        input logic cv, input logic lv, input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.c_req = creq; v.c_we = cwe; v.c_addr = caddr; v.c_wdata = cwdata;
        v.l_req = lreq; v.l_we = lwe; v.l_addr = laddr; v.l_wdata = lwdata;
        v.e_cg = cg; v.e_lg = lg; v.e_men = men; v.e_mwe = mwe;
        v.e_maddr = maddr; v.e_mwdata = mwdata; v.e_cv = cv; v.e_lv = lv; v.e_rdata = rd;
        return v;
    endfunction

    vec_t tv [13];

    initial begin
        rst1 = 1'b1; c_req1 = 0; c_we1 = 0; c_addr1 = 0; c_wdata1 = 0;
        l_req1 = 0; l_we1 = 0; l_addr1 = 0; l_wdata1 = 0;
        rst3 = 1'b1; c_req3 = 0; c_we3 = 0; c_addr3 = 0; c_wdata3 = 0;
        l_req3 = 0; l_we3 = 0; l_addr3 = 0; l_wdata3 = 0;

        //          rst creq cwe caddr  cwdata         lreq lwe laddr  lwdata        cg lg men mwe maddr  mwdata        cv lv rdata
        tv[0]  = mk(1,  1,   0,  32'h10, 0,            0,   0,  0,     0,            0, 0, 0,  0,  0,     0,            0, 0, 0);
        tv[1]  = mk(0,  0,   0,  0,      0,            0,   0,  0,     0,            0, 0, 0,  0,  0,     0,            0, 0, 0);
        tv[2]  = mk(0,  1,   0,  32'h10, 0,            0,   0,  0,     0,            1, 0, 1,  0,  32'h10,0,            0, 0, 0);
        tv[3]  = mk(0,  0,   0,  0,      0,            0,   0,  0,     0,            0, 0, 0,  0,  0,     0,            1, 0, 32'hA500_0004);
        tv[4]  = mk(0,  0,   0,  0,      0,            0,   0,  0,     0,            0, 0, 0,  0,  0,     0,            0, 0, 0);
        tv[5]  = mk(0,  1,   1,  32'h20, 32'hDEADBEEF, 0,   0,  0,     0,            1, 0, 1,  1,  32'h20,32'hDEADBEEF, 0, 0, 0);
        tv[6]  = mk(0,  1,   0,  32'h20, 0,            0,   0,  0,     0,            1, 0, 1,  0,  32'h20,0,            0, 0, 0);
        tv[7]  = mk(0,  0,   0,  0,      0,            0,   0,  0,     0,            0, 0, 0,  0,  0,     0,            1, 0, 32'hDEADBEEF);
        tv[8]  = mk(0,  0,   0,  0,      0,            1,   0,  32'h24,0,            0, 1, 1,  0,  32'h24,0,            0, 0, 0);
        tv[9]  = mk(0,  1,   0,  32'h10, 0,            0,   0,  0,     0,            0, 0, 0,  0,  0,     0,            0, 1, 32'hA500_0009);
        tv[10] = mk(0,  1,   0,  32'h10, 0,            0,   0,  0,     0,            1, 0, 1,  0,  32'h10,0,            0, 0, 0);
        tv[11] = mk(0,  0,   0,  0,      0,            0,   0,  0,     0,            0, 0, 0,  0,  0,     0,            1, 0, 32'hA500_0004);
        tv[12] = mk(0,  0,   0,  0,      0,            1,   1,  32'h28,32'h12345678, 0, 1, 1,  1,  32'h28,32'h12345678, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);

        // Table-driven vectors on the MEM_LAT=1 instance
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst1 = tv[i].rst;
            c_req1 = tv[i].c_req; c_we1 = tv[i].c_we; c_addr1 = tv[i].c_addr; c_wdata1 = tv[i].c_wdata;
            l_req1 = tv[i].l_req; l_we1 = tv[i].l_we; l_addr1 = tv[i].l_addr; l_wdata1 = tv[i].l_wdata;
            #1;
            chk("c_gnt",    i, 32'(c_gnt1),    32'(tv[i].e_cg));
            chk("l_gnt",    i, 32'(l_gnt1),    32'(tv[i].e_lg));
            chk("m_en",     i, 32'(m_en1),     32'(tv[i].e_men));
            chk("m_we",     i, 32'(m_we1),     32'(tv[i].e_mwe));
            chk("m_addr",   i, m_addr1,        tv[i].e_maddr);
            chk("m_wdata",  i, m_wdata1,       tv[i].e_mwdata);
            chk("c_rvalid", i, 32'(c_rvalid1), 32'(tv[i].e_cv));
            chk("l_rvalid", i, 32'(l_rvalid1), 32'(tv[i].e_lv));
            if (tv[i].e_cv || tv[i].e_lv) chk("rdata", i, rdata1, tv[i].e_rdata);
        end

        // Both requesters held after reset: alternation (or core-only when fixed priority)
        @(negedge clk);
        rst1 = 1; c_req1 = 0; l_req1 = 0; c_we1 = 0; l_we1 = 0; c_wdata1 = 0; l_wdata1 = 0;
        @(negedge clk);
        rst1 = 0;
        c_req1 = 1; c_addr1 = 32'h14;
        l_req1 = 1; l_addr1 = 32'h18;
        #1;
        for (int k = 0; k < 12; k++) begin
            logic exp_loader;
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
`ifdef ARB_FIXED_PRIO_EN
            exp_loader = 1'b0;
`else
            exp_loader = ((k / 2) % 2) == 1;
`endif
            if (k % 2 == 0) begin
                chk("alt_c_gnt", k, 32'(c_gnt1), 32'(!exp_loader));
                chk("alt_l_gnt", k, 32'(l_gnt1), 32'(exp_loader));
                chk("alt_m_addr", k, m_addr1, exp_loader ? 32'h18 : 32'h14);
            end else begin
                chk("alt_gnt_idle", k, 32'({c_gnt1, l_gnt1}), 32'h0);
                chk("alt_c_rvalid", k, 32'(c_rvalid1), 32'(!exp_loader));
                chk("alt_l_rvalid", k, 32'(l_rvalid1), 32'(exp_loader));
                chk("alt_rdata", k, rdata1, exp_loader ? 32'hA500_0006 : 32'hA500_0005);
            end
        end

        // Reset during the read wait aborts the access and restores the tie-break
        @(negedge clk);
        rst1 = 1; c_req1 = 0; l_req1 = 0;
        @(negedge clk);
        rst1 = 0; c_req1 = 1; c_addr1 = 32'h10;
        #1;
        chk("abort_issue", 0, 32'(c_gnt1), 32'h1);
        @(negedge clk);
        rst1 = 1; c_req1 = 0;
        #1;
        chk("abort_rvalid_rst", 0, 32'({c_rvalid1, l_rvalid1}), 32'h0);
        @(negedge clk);
        rst1 = 0;
        #1;
        chk("abort_rvalid_after", 0, 32'({c_rvalid1, l_rvalid1}), 32'h0);
        chk("abort_m_en", 0, 32'(m_en1), 32'h0);
        @(negedge clk);
        c_req1 = 1; c_addr1 = 32'h14;
        l_req1 = 1; l_addr1 = 32'h18;
        #1;
        chk("abort_tie_c", 0, 32'(c_gnt1), 32'h1);
        chk("abort_tie_l", 0, 32'(l_gnt1), 32'h0);
        @(negedge clk);
        c_req1 = 0; l_req1 = 0;
        #1;
        chk("abort_next_rvalid", 0, 32'(c_rvalid1), 32'h1);

        // MEM_LAT=3: loader read, core waits through the three wait cycles
        @(negedge clk);
        rst3 = 0; l_req3 = 1; l_addr3 = 32'h2C;
        #1;
        chk("lat3_l_gnt", 0, 32'(l_gnt3), 32'h1);
        chk("lat3_m_addr", 0, m_addr3, 32'h2C);
        chk("lat3_m_we", 0, 32'({m_we3, m_wdata3 != 32'h0}), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            l_req3 = 0; c_req3 = 1; c_addr3 = 32'h30;
            #1;
            chk("lat3_c_gnt", k, 32'(c_gnt3), 32'h0);
            chk("lat3_m_en", k, 32'(m_en3), 32'h0);
            chk("lat3_l_rvalid", k, 32'(l_rvalid3), 32'(k == 3));
            chk("lat3_c_rvalid", k, 32'(c_rvalid3), 32'h0);
            if (k == 3) chk("lat3_rdata", k, rdata3, 32'hA500_000B);
        end
        @(negedge clk);
        #1;
        chk("lat3_c_gnt", 4, 32'(c_gnt3), 32'h1);
        chk("lat3_l_gnt", 4, 32'(l_gnt3), 32'h0);
        @(negedge clk);
        c_req3 = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
